bcd_count_ctrl: RTL

//  Controller that sequences the 3-digit (12-bit) BCD incrementer datapath as a run/stop event counter.

---
 rtl/bcd_count_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/bcd_count_ctrl.sv
// bcd_count_ctrl: run/stop controller around a 3-digit BCD incrementer.
// It owns the count register, the prescaler, the target compare and the
// 999 -> 000 wrap. It also provides a one-deep snapshot handshake for the
// display/readout path.
// Optional build macro: BCD_CNT_SAT_EN. When it is defined, the counter
// saturates at 999 and finishes instead of wrapping.
module bcd_count_ctrl #(
    parameter int PRESCALE = 4,
    parameter int PS_W     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        load,
    input  logic [11:0] load_val,
    input  logic [11:0] target,
    output logic [11:0] count,
    output logic        running,
    output logic        done,
    output logic        wrap,
    output logic        load_err,
    input  logic        snap_req,
    output logic        snap_valid,
    input  logic        snap_ready,
    output logic [11:0] snap_data
);

    localparam logic [1:0]      ST_IDLE = 2'd0;
    localparam logic [1:0]      ST_RUN  = 2'd1;
    localparam logic [1:0]      ST_DONE = 2'd2;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [11:0]     BCD_MAX = 12'h999;

    logic [1:0]      state_q, state_d;
    logic [11:0]     count_q, count_d;
    logic [PS_W-1:0] ps_q, ps_d;
    logic            done_q, done_d;
    logic            wrap_q, wrap_d;
    logic            loadErr_q, loadErr_d;
    logic            snapValid_q, snapValid_d;
    logic [11:0]     snapData_q, snapData_d;

    logic        loadOk;
    logic        loadBad;
    logic [11:0] stepInc;

    function automatic logic digitsValid(input logic [11:0] v);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v[11:8] <= 4'd9);
    endfunction

    // This is a plain BCD incrementer, the same as the datapath unit. It maps 999 to
    // 12'hA00, so the step logic intercepts 999 before this value is used.
    function automatic logic [11:0] bcdInc(input logic [11:0] v);
        logic [3:0] u, t, h;
        u = v[3:0];
        t = v[7:4];
        h = v[11:8];
        if (u == 4'd9) begin
            u = 4'd0;
            if (t == 4'd9) begin
                t = 4'd0;
                h = h + 4'd1;
            end else begin
                t = t + 4'd1;
            end
        end else begin
            u = u + 4'd1;
        end
        return {h, t, u};
    endfunction

    assign loadOk  = load && digitsValid(load_val);
    assign loadBad = load && !digitsValid(load_val);
    assign stepInc = bcdInc(count_q);

    // Control FSM, prescaler and count update. A valid load has the highest priority.
    // A rejected load only raises load_err, and the other inputs still act.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        ps_d      = ps_q;
        done_d    = 1'b0;
        wrap_d    = 1'b0;
        loadErr_d = loadBad;
        if (loadOk) begin
            count_d = load_val;
            ps_d    = '0;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_IDLE;
                        ps_d    = '0;
                    end else if (ps_q == PS_LAST) begin
                        ps_d = '0;
                        if (count_q == BCD_MAX) begin
`ifdef BCD_CNT_SAT_EN
                            state_d = ST_DONE;
                            done_d  = 1'b1;
`else
                            count_d = 12'h000;
                            wrap_d  = 1'b1;
                            if (target == 12'h000) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end
`endif
                        end else begin
                            count_d = stepInc;
                            if (stepInc == target) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end
                        end
                    end else begin
                        ps_d = ps_q + 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        state_d = ST_RUN;
                        ps_d    = '0;
                    end
                end
            endcase
        end
    end

    // Snapshot handshake. A pending snapshot blocks new requests until it is accepted.
    always_comb begin
        snapValid_d = snapValid_q;
        snapData_d  = snapData_q;
        if (snapValid_q) begin
            if (snap_ready) begin
                snapValid_d = 1'b0;
            end
        end else if (snap_req) begin
            snapValid_d = 1'b1;
            snapData_d  = count_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= 12'h000;
            ps_q        <= '0;
            done_q      <= 1'b0;
            wrap_q      <= 1'b0;
            loadErr_q   <= 1'b0;
            snapValid_q <= 1'b0;
            snapData_q  <= 12'h000;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            ps_q        <= ps_d;
            done_q      <= done_d;
            wrap_q      <= wrap_d;
            loadErr_q   <= loadErr_d;
            snapValid_q <= snapValid_d;
            snapData_q  <= snapData_d;
        end
    end

    assign count      = count_q;
    assign running    = (state_q == ST_RUN);
    assign done       = done_q;
    assign wrap       = wrap_q;
    assign load_err   = loadErr_q;
    assign snap_valid = snapValid_q;
    assign snap_data  = snapData_q;

endmodule
